// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, address field widths
// and idle bus values used by the init, arbiter, write and read blocks.
package sdram_pkg;

  // Command word layout is {cs_n, ras_n, cas_n, we_n}
  typedef logic [3:0] sdram_cmd_t;

  localparam sdram_cmd_t CMD_NOP       = 4'b0111;
  localparam sdram_cmd_t CMD_ACTIVE    = 4'b0011;
  localparam sdram_cmd_t CMD_READ      = 4'b0101;
  localparam sdram_cmd_t CMD_WRITE     = 4'b0100;
  localparam sdram_cmd_t CMD_BST       = 4'b0110;
  localparam sdram_cmd_t CMD_PRECHARGE = 4'b0010;

  // Request address is {ba, row, col}
  localparam int unsigned BA_W  = 2;
  localparam int unsigned ROW_W = 13;
  localparam int unsigned COL_W = 9;

  localparam logic [BA_W-1:0]  BA_IDLE      = 2'b11;
  localparam logic [ROW_W-1:0] ADDR_IDLE    = 13'h1FFF;
  // A10 high selects all banks for PRECHARGE
  localparam logic [ROW_W-1:0] ADDR_PRE_ALL = 13'h0400;

endpackage

// File: rtl/ddr_ctrl_rd.sv
// SDRAM read-path controller: one full-page read per request, issuing
// ACTIVE -> READ -> BST -> PRECHARGE-all and returning the captured words.
// Command/address outputs are registered from the current state, so each
// command appears on the bus one cycle after its state is entered.
module ddr_ctrl_rd #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned BL_W     = 10,
  parameter int unsigned TRCD_CLK = 2,
  parameter int unsigned CAS_LAT  = 3,
  parameter int unsigned TRP_CLK  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [BL_W-1:0]   rd_burst_len_i,
  input  logic [DATA_W-1:0] rd_sdram_data_i,
  output logic              rd_ack_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_end_o,
  output logic [3:0]        rd_cmd_o,
  output logic [1:0]        rd_ba_o,
  output logic [12:0]       rd_addr_o
);
  import sdram_pkg::*;

  // Two spare bits hold the largest RD_DATA count, CAS_LAT + BL - 2
  localparam int unsigned CNT_W = BL_W + 2;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t TRCD_LAST = cnt_t'(TRCD_CLK - 2);
  localparam cnt_t TRP_LAST  = cnt_t'((TRP_CLK > 1) ? (TRP_CLK - 2) : 0);
  localparam cnt_t CAS_CNT   = cnt_t'(CAS_LAT);

  typedef enum logic [2:0] {
    StIdle, StAct, StTrcd, StRd, StRdData, StPre, StTrp, StEnd
  } state_e;

  state_e            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic [BA_W-1:0]   ba_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [BL_W-1:0]   bl_q;
  sdram_cmd_t        cmd_q, cmd_d;
  logic [BA_W-1:0]   ba_out_q, ba_out_d;
  logic [ROW_W-1:0]  addr_out_q, addr_out_d;
  logic              ack_q, ack_d;
  logic              end_q, end_d;
  logic [DATA_W-1:0] data_q;

  logic accept;
  cnt_t bst_cnt, exit_cnt;

  assign accept   = (state_q == StIdle) && init_end_i && rd_en_i;
  assign bst_cnt  = cnt_t'(bl_q) - cnt_t'(1);
  assign exit_cnt = cnt_t'(bl_q) + CAS_CNT - cnt_t'(2);

  // State register and shared TRCD/RD_DATA/TRP counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch request address and burst length on accept; BL of 0 reads one word
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ba_q  <= '0;
      row_q <= '0;
      col_q <= '0;
      bl_q  <= '0;
    end else if (accept) begin
      ba_q  <= rd_addr_i[COL_W+ROW_W +: BA_W];
      row_q <= rd_addr_i[COL_W +: ROW_W];
      col_q <= rd_addr_i[COL_W-1:0];
      bl_q  <= (rd_burst_len_i == '0) ? BL_W'(1) : rd_burst_len_i;
    end
  end

  // Next state, counter and next registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + cnt_t'(1);
    cmd_d      = CMD_NOP;
    ba_out_d   = BA_IDLE;
    addr_out_d = ADDR_IDLE;
    ack_d      = 1'b0;
    end_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) state_d = StAct;
      end
      StAct: begin
        cmd_d      = CMD_ACTIVE;
        ba_out_d   = ba_q;
        addr_out_d = row_q;
        cnt_d      = '0;
        state_d    = StTrcd;
      end
      StTrcd: begin
        if (cnt_q == TRCD_LAST) begin
          cnt_d   = '0;
          state_d = StRd;
        end
      end
      StRd: begin
        cmd_d      = CMD_READ;
        ba_out_d   = ba_q;
        addr_out_d = {{(ROW_W-COL_W){1'b0}}, col_q};
        cnt_d      = '0;
        state_d    = StRdData;
      end
      StRdData: begin
        if (cnt_q == bst_cnt) cmd_d = CMD_BST;
        // Word k reaches the pins at count CAS_LAT + k
        if (cnt_q >= CAS_CNT) ack_d = 1'b1;
        if (cnt_q == exit_cnt) begin
          cnt_d   = '0;
          state_d = StPre;
        end
      end
      StPre: begin
        cmd_d      = CMD_PRECHARGE;
        ba_out_d   = ba_q;
        addr_out_d = ADDR_PRE_ALL;
        // Last word is captured in the same cycle PRECHARGE is decoded
        ack_d      = 1'b1;
        cnt_d      = '0;
        state_d    = (TRP_CLK > 1) ? StTrp : StEnd;
      end
      StTrp: begin
        if (cnt_q == TRP_LAST) begin
          cnt_d   = '0;
          state_d = StEnd;
        end
      end
      StEnd: begin
        end_d   = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Registered command/address/status outputs and DQ capture
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_q      <= CMD_NOP;
      ba_out_q   <= BA_IDLE;
      addr_out_q <= ADDR_IDLE;
      ack_q      <= 1'b0;
      end_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      cmd_q      <= cmd_d;
      ba_out_q   <= ba_out_d;
      addr_out_q <= addr_out_d;
      ack_q      <= ack_d;
      end_q      <= end_d;
      if (ack_d) data_q <= rd_sdram_data_i;
    end
  end

  assign rd_cmd_o  = cmd_q;
  assign rd_ba_o   = ba_out_q;
  assign rd_addr_o = addr_out_q;
  assign rd_ack_o  = ack_q;
  assign rd_end_o  = end_q;
  assign rd_data_o = data_q;

endmodule

// File: tb/tb_ddr_ctrl_rd.sv
// Self-checking bench for ddr_ctrl_rd: a transaction-level model predicts the
// command schedule from the request, and a DQ model returns random words.
module tb_ddr_ctrl_rd;

  localparam int TRCD = 2;
  localparam int CAS  = 3;
  localparam int TRP  = 2;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RDC = 4'b0101;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] PRE = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        init_end_i = 1'b0;
  logic        rd_en_i = 1'b0;
  logic [23:0] rd_addr_i = '0;
  logic [9:0]  rd_burst_len_i = '0;
  logic [15:0] rd_sdram_data_i = '0;
  logic        rd_ack_o;
  logic [15:0] rd_data_o;
  logic        rd_end_o;
  logic [3:0]  rd_cmd_o;
  logic [1:0]  rd_ba_o;
  logic [12:0] rd_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  ddr_ctrl_rd #(
    .ADDR_W(24), .DATA_W(16), .BL_W(10), .TRCD_CLK(TRCD), .CAS_LAT(CAS), .TRP_CLK(TRP)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .init_end_i     (init_end_i),
    .rd_en_i        (rd_en_i),
    .rd_addr_i      (rd_addr_i),
    .rd_burst_len_i (rd_burst_len_i),
    .rd_sdram_data_i(rd_sdram_data_i),
    .rd_ack_o       (rd_ack_o),
    .rd_data_o      (rd_data_o),
    .rd_end_o       (rd_end_o),
    .rd_cmd_o       (rd_cmd_o),
    .rd_ba_o        (rd_ba_o),
    .rd_addr_o      (rd_addr_o)
  );

  // Runs one request; must be entered at a negedge with the DUT idle. Cycle n is
  // the period after the n-th rising edge, edge 0 being the accept edge.
  // hold keeps rd_en_i high for a back-to-back follow-on; abort_at >= 0 resets
  // the DUT mid-cycle at that cycle.
  task automatic run_txn(input string tag, input logic [23:0] addr, input logic [9:0] bl_in,
                         input bit hold, input int abort_at);
    int bl, t_rd, t_bst, t_pre, t_end, last, n_ack;
    logic [15:0] words[$];
    logic [3:0]  e_cmd;
    logic [1:0]  e_ba;
    logic [12:0] e_a;
    logic        e_ack, e_end;
    bl    = (bl_in == 10'd0) ? 1 : int'(bl_in);
    t_rd  = 1 + TRCD;
    t_bst = t_rd + bl;
    t_pre = t_rd + CAS + bl;
    t_end = t_pre + TRP;
    last  = hold ? t_end : t_end + 3;
    n_ack = 0;
    for (int i = 0; i < bl; i++) words.push_back(16'($urandom));
    rd_addr_i       = addr;
    rd_burst_len_i  = bl_in;
    rd_en_i         = 1'b1;
    init_end_i      = 1'b1;
    rd_sdram_data_i = 16'($urandom);
    for (int n = 0; n <= last; n++) begin
      int k;
      int idx;
      @(negedge sys_clk);
      e_cmd = NOP;
      e_ba  = 2'b11;
      e_a   = 13'h1FFF;
      if (n == 1) begin
        e_cmd = ACT; e_ba = addr[23:22]; e_a = addr[21:9];
      end else if (n == t_rd) begin
        e_cmd = RDC; e_ba = addr[23:22]; e_a = {4'b0000, addr[8:0]};
      end else if (n == t_bst) begin
        e_cmd = BST;
      end else if (n == t_pre) begin
        e_cmd = PRE; e_ba = addr[23:22]; e_a = 13'h0400;
      end
      k     = n - (t_rd + CAS + 1);
      e_ack = (k >= 0) && (k < bl);
      e_end = (n == t_end);

      n_tests++;
      if ({rd_cmd_o, rd_ba_o, rd_addr_o} !== {e_cmd, e_ba, e_a}) begin
        n_fail++;
        $display("FAIL %s cmd/ba/addr cycle %0d: got %h/%h/%h, want %h/%h/%h", tag, n,
                 rd_cmd_o, rd_ba_o, rd_addr_o, e_cmd, e_ba, e_a);
      end
      n_tests++;
      if (rd_ack_o !== e_ack) begin
        n_fail++;
        $display("FAIL %s ack cycle %0d: got %b, want %b", tag, n, rd_ack_o, e_ack);
      end
      if (rd_ack_o === 1'b1) n_ack++;
      if (e_ack) begin
        n_tests++;
        if (rd_data_o !== words[k]) begin
          n_fail++;
          $display("FAIL %s data word %0d: got %h, want %h", tag, k, rd_data_o, words[k]);
        end
      end
      n_tests++;
      if (rd_end_o !== e_end) begin
        n_fail++;
        $display("FAIL %s end cycle %0d: got %b, want %b", tag, n, rd_end_o, e_end);
      end

      if (n == abort_at) begin
        #2 sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rd_cmd_o, rd_ba_o, rd_addr_o, rd_ack_o, rd_end_o, rd_data_o} !==
            {NOP, 2'b11, 13'h1FFF, 1'b0, 1'b0, 16'h0000}) begin
          n_fail++;
          $display("FAIL %s async reset: got cmd=%h ba=%h a=%h ack=%b end=%b d=%h, want reset values",
                   tag, rd_cmd_o, rd_ba_o, rd_addr_o, rd_ack_o, rd_end_o, rd_data_o);
        end
        return;
      end

      // Scramble request inputs after accept: the latched copy must be used
      rd_addr_i      = 24'($urandom);
      rd_burst_len_i = 10'($urandom);
      if (n < t_end) begin
        rd_en_i    = hold ? 1'b1 : ($urandom_range(3) == 0);
        init_end_i = 1'($urandom);
      end else begin
        rd_en_i    = hold;
        init_end_i = 1'b1;
      end
      idx = n - (t_rd + CAS);
      rd_sdram_data_i = (idx >= 0 && idx < bl) ? words[idx] : 16'($urandom);
    end
    n_tests++;
    if (n_ack != bl) begin
      n_fail++;
      $display("FAIL %s ack count: got %0d, want %0d", tag, n_ack, bl);
    end
  endtask

  task automatic test_reset();
    #3 sys_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rd_cmd_o, rd_ba_o, rd_addr_o, rd_ack_o, rd_end_o, rd_data_o} !==
        {NOP, 2'b11, 13'h1FFF, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset values: got cmd=%h ba=%h a=%h ack=%b end=%b d=%h, want reset values",
               rd_cmd_o, rd_ba_o, rd_addr_o, rd_ack_o, rd_end_o, rd_data_o);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_no_init();
    init_end_i = 1'b0;
    rd_en_i    = 1'b1;
    rd_addr_i  = 24'h123456;
    rd_burst_len_i = 10'd4;
    for (int n = 0; n < 30; n++) begin
      @(negedge sys_clk);
      n_tests++;
      if (rd_cmd_o !== NOP || rd_ack_o !== 1'b0 || rd_end_o !== 1'b0) begin
        n_fail++;
        $display("FAIL no_init cycle %0d: got cmd=%h ack=%b end=%b, want NOP/0/0",
                 n, rd_cmd_o, rd_ack_o, rd_end_o);
      end
    end
    rd_en_i    = 1'b0;
    init_end_i = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_nominal();
    run_txn("nominal", 24'h957812, 10'd4, 1'b0, -1);
  endtask

  task automatic test_bl_edges();
    run_txn("bl1", 24'($urandom), 10'd1, 1'b0, -1);
    run_txn("bl0", 24'($urandom), 10'd0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_txn("random", 24'($urandom), 10'($urandom_range(40, 1)), 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_0", 24'($urandom), 10'($urandom_range(12, 1)), 1'b1, -1);
    run_txn("b2b_1", 24'($urandom), 10'($urandom_range(12, 1)), 1'b1, -1);
    run_txn("b2b_2", 24'($urandom), 10'($urandom_range(12, 1)), 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    run_txn("rst_mid", 24'($urandom), 10'd8, 1'b0, 1 + TRCD + CAS + 2);
    rd_en_i = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge sys_clk);
      n_tests++;
      if (rd_cmd_o !== NOP || rd_ack_o !== 1'b0 || rd_end_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid idle cycle %0d: got cmd=%h ack=%b end=%b, want NOP/0/0",
                 n, rd_cmd_o, rd_ack_o, rd_end_o);
      end
    end
    run_txn("after_rst", 24'($urandom), 10'd5, 1'b0, -1);
  endtask

  task automatic test_bl_max();
    run_txn("bl_max", 24'($urandom), 10'd1023, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_no_init();
    test_nominal();
    test_bl_edges();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_bl_max();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_ctrl_rd.md
# ddr_ctrl_rd

SDRAM read-path controller, the read-side counterpart of `ddr_ctrl_wr` inside `sdram_ctrl`. It accepts one full-page-mode read request from the arbiter after initialisation completes. It issues ACTIVE → READ → BURST TERMINATE → PRECHARGE-all to the SDRAM command mux and returns exactly `rd_burst_len_i` captured data words with a per-word valid strobe. It pulses `rd_end_o` when the bank is precharged and the block is idle again.

## Interface
Parameters:
- `ADDR_W`, 24: request address width, decoded as `{ba[1:0], row[12:0], col[8:0]}`.
- `DATA_W`, 16: SDRAM data width.
- `BL_W`, 10: burst length counter width.
- `TRCD_CLK`, 2: ACTIVE→READ spacing in clocks, ≥2.
- `CAS_LAT`, 3: CAS latency in clocks, 2 or 3, matching the mode register.
- `TRP_CLK`, 2: PRECHARGE→end spacing in clocks, ≥1.

Ports:
- `sys_clk`  in  1  single clock, rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `init_end_i`  in  1  SDRAM initialisation done; requests are ignored while low.
- `rd_en_i`  in  1  read request, sampled in IDLE only.
- `rd_addr_i`  in  ADDR_W  start address, latched on accept.
- `rd_burst_len_i`  in  BL_W  number of words to read, latched on accept; 0 is treated as 1.
- `rd_sdram_data_i`  in  DATA_W  SDRAM DQ input.
- `rd_ack_o`  out  1  high for exactly one cycle per returned word.
- `rd_data_o`  out  DATA_W  returned word, valid when `rd_ack_o`=1.
- `rd_end_o`  out  1  one-cycle pulse when the transaction is complete.
- `rd_cmd_o`  out  4  `{cs_n, ras_n, cas_n, we_n}`.
- `rd_ba_o`  out  2  bank address.
- `rd_addr_o`  out  13  SDRAM A[12:0].

## Operation
- Commands: NOP=4'b0111, ACTIVE=4'b0011, READ=4'b0101, BST=4'b0110, PRECHARGE=4'b0010.
- FSM states: IDLE, ACT, TRCD, RD, RD_DATA, PRE, TRP, END.
  - IDLE→ACT on `init_end_i && rd_en_i`; the address and burst length are latched on that edge.
  - ACT (1 cycle)→TRCD (TRCD_CLK−1 cycles)→RD (1 cycle)→RD_DATA→PRE (1 cycle)→TRP (TRP_CLK−1 cycles; skipped when TRP_CLK=1)→END (1 cycle)→IDLE.
- Command and address per state:
  - ACT: `rd_ba_o`=latched ba, `rd_addr_o`=row.
  - RD: `rd_ba_o`=ba, `rd_addr_o`={4'b0000, col}. A10=0, no auto-precharge.
  - PRE: `rd_ba_o`=ba, `rd_addr_o`=13'h0400 (A10=1, all banks).
  - All other states: NOP, `rd_ba_o`=2'b11, `rd_addr_o`=13'h1FFF.
- RD_DATA counter `cnt` counts from 0, where cnt=0 is the cycle after READ.
  - BST is issued when cnt = BL−1.
  - RD_DATA exits when cnt = CAS_LAT+BL−2.
- Data path: `rd_data_o` and `rd_ack_o` are registered from the SDRAM pins. The word present on the pins at cycle READ+CAS_LAT+k is output with `rd_ack_o` at cycle READ+CAS_LAT+k+1, for k = 0..BL−1.
- `rd_en_i` is ignored outside IDLE. A request held high is re-accepted on the first cycle back in IDLE.
- `init_end_i` dropping mid-transaction has no effect; the transaction completes.
- All command, address and status outputs are registered.

## Timing
- Reset values (asynchronous):
  - `rd_cmd_o`=NOP, `rd_ba_o`=2'b11, `rd_addr_o`=13'h1FFF.
  - `rd_ack_o`=0, `rd_end_o`=0, `rd_data_o`=0.
  - State=IDLE, counters=0.
- Reset mid-transaction: all outputs return to reset values immediately. No PRECHARGE is issued; the init block re-precharges.
- Cycle numbering: accept edge = cycle 0, then:
  - ACTIVE at cycle 1.
  - READ at 1+TRCD_CLK.
  - BST at READ+BL.
  - PRECHARGE at READ+CAS_LAT+BL.
  - `rd_end_o` at PRE+TRP_CLK.
- Earliest next accept is the cycle after `rd_end_o`.
- BL=1: BST in the cycle directly after READ, one `rd_ack_o` pulse.
- Latched BL=0 behaves exactly as BL=1.
- Maximum BL=2^BL_W−1 (1023). Column wrap within the page is handled by the SDRAM; the controller does not check it.

## Structure
- Shared package `sdram_pkg`: command constants (NOP/ACTIVE/READ/BST/PRECHARGE/WRITE), address field widths, and the `sdram_cmd_t` typedef. It is shared with `ddr_ctrl_wr`, init and arbiter.
- The FSM state enum stays local to this block.
- No sub-module: one FSM plus one shared cycle counter (reused for TRCD, RD_DATA and TRP) and the data capture register.

## Test plan
- Reset: assert `sys_rst_n`=0 mid-cycle → all outputs at reset values asynchronously. After release with `rd_en_i`=1 and `init_end_i`=0 → ACTIVE never issued.
- Nominal read, TRCD 2 / CAS 3 / TRP 2, BL=4, addr=24'h957812, DQ model driving A0..A3 at cycles 6–9:
  - ACTIVE at cycle 1 (ba=2, A=13'h0ABC).
  - READ at cycle 3 (A=13'h0012).
  - BST at cycle 7.
  - `rd_ack_o` at cycles 7–10 with data A0..A3.
  - PRE at cycle 10 (A=13'h0400).
  - `rd_end_o` at cycle 12.
- BL=1 and BL=0: BST at READ+1, exactly one ack, PRE at READ+4.
- BL=1023: exactly 1023 acks, BST at READ+1023, no counter overflow.
- Back-to-back: `rd_en_i` held high → second ACTIVE on the cycle after `rd_end_o`+1. A `rd_en_i` pulse mid-transaction is ignored.
- Reset asserted during RD_DATA → acks stop at once, IDLE after release, next request runs nominally.
